// File: rtl/lcd_rgb_capture_if.sv
// lcd_rgb_capture_if: bundle between an RGB888 DE-mode source and the
// capture block.
//   lcd_de, lcd_rgb            : panel-side data enable and pixel
//   pix_valid/data/x/y/sof/eol : reconstructed pixel stream
//   frame_done                 : end-of-frame pulse
//   meas_h_disp, meas_v_disp   : measured geometry of the last frame
//   err_size, locked           : geometry status
// master = the panel/source side, slave = the capture block.
interface lcd_rgb_capture_if #(
    parameter int CNT_W = 11
);
    logic             lcd_de;
    logic [23:0]      lcd_rgb;
    logic             pix_valid;
    logic [23:0]      pix_data;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             pix_sof;
    logic             pix_eol;
    logic             frame_done;
    logic [CNT_W-1:0] meas_h_disp;
    logic [CNT_W-1:0] meas_v_disp;
    logic             err_size;
    logic             locked;

    modport master (
        output lcd_de, lcd_rgb,
        input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
        input  frame_done, meas_h_disp, meas_v_disp, err_size, locked
    );

    modport slave (
        input  lcd_de, lcd_rgb,
        output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
        output frame_done, meas_h_disp, meas_v_disp, err_size, locked
    );
endinterface

// File: rtl/lcd_rgb_capture.sv
// lcd_rgb_capture: DE-mode RGB888 receiver. Rebuilds x/y per pixel from
// lcd_de alone (HS/VS are not used), finds frame boundaries from long
// DE-low gaps, measures the active geometry and reports lock once the
// geometry has been stable and error-free for LOCK_FRAMES frames.
// Ports:
//   lcd_pclk : pixel clock (only clock)
//   rst      : asynchronous active-high reset
//   bus      : slave side of lcd_rgb_capture_if (lcd_de/lcd_rgb in,
//              pixel stream and geometry status out)
// Pixel outputs are registered two edges after the edge that samples
// lcd_de/lcd_rgb.
module lcd_rgb_capture #(
    parameter int CNT_W       = 11,
    parameter int VGAP_MIN    = 1024,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             lcd_pclk,
    input  logic             rst,
    lcd_rgb_capture_if.slave bus
);
    localparam int               MW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CMAX     = '1;
    localparam logic [CNT_W-1:0] GAP_TOP  = CNT_W'(VGAP_MIN);
    localparam logic [MW-1:0]    LOCK_TOP = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, WAIT_SOF, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic             s1_de, s2_de, p_de;
    logic [23:0]      s1_rgb, s2_rgb;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic             vld_q, vld_d, sof_q, sof_d, eol_q, eol_d;
    logic             fd_q, fd_d, err_q, err_d, lock_q, lock_d;
    logic [23:0]      data_q, data_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] ref_q, ref_d;   // last x of the first line
    logic [CNT_W-1:0] mh_q, mh_d, mv_q, mv_d;
    logic [CNT_W-1:0] h_new, v_new;
    logic [MW-1:0]    mc_q, mc_d;
    logic             gap_full, pix_go;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    assign gap_full = (gcnt_q == GAP_TOP);

    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            s1_de   <= 1'b0;
            s2_de   <= 1'b0;
            p_de    <= 1'b0;
            s1_rgb  <= '0;
            s2_rgb  <= '0;
            gcnt_q  <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
            data_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ref_q   <= '0;
            mh_q    <= '0;
            mv_q    <= '0;
            mc_q    <= '0;
        end else begin
            state_q <= state_d;
            s1_de   <= bus.lcd_de;
            s1_rgb  <= bus.lcd_rgb;
            s2_de   <= s1_de;
            s2_rgb  <= s1_rgb;
            p_de    <= s2_de;
            gcnt_q  <= gcnt_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
            data_q  <= data_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ref_q   <= ref_d;
            mh_q    <= mh_d;
            mv_q    <= mv_d;
            mc_q    <= mc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gcnt_d  = s1_de ? '0 : (gap_full ? gcnt_q : gcnt_q + 1'b1);
        pix_go  = 1'b0;
        vld_d   = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        fd_d    = 1'b0;
        data_d  = data_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        ref_d   = ref_q;
        mh_d    = mh_q;
        mv_d    = mv_q;
        mc_d    = mc_q;
        lock_d  = lock_q;
        h_new   = sat_inc(ref_q);
        v_new   = sat_inc(y_q);

        case (state_q)
            SEARCH: begin
                if (gap_full) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (s2_de) begin
                    state_d = ACTIVE;
                    pix_go  = 1'b1;
                    sof_d   = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    err_d   = 1'b0;
                end
            end
            ACTIVE: begin
                // A full gap guarantees s2_de=0, so frame_done never
                // coincides with a pixel.
                if (gap_full) begin
                    state_d = WAIT_SOF;
                    fd_d    = 1'b1;
                    mh_d    = h_new;
                    mv_d    = v_new;
                    if (!err_q && h_new == mh_q && v_new == mv_q)
                        mc_d = (mc_q >= LOCK_TOP) ? mc_q : mc_q + 1'b1;
                    else
                        mc_d = err_q ? '0 : MW'(1);
                    lock_d = (mc_d >= LOCK_TOP);
                end else if (s2_de) begin
                    pix_go = 1'b1;
                    if (!p_de) begin
                        x_d = '0;
                        if (y_q == CMAX) err_d = 1'b1;
                        else             y_d   = y_q + 1'b1;
                    end else if (x_q == CMAX) begin
                        err_d = 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        // s1 holds the next sample, so de=0 there marks end of line.
        if (pix_go) begin
            vld_d  = 1'b1;
            data_d = s2_rgb;
            eol_d  = ~s1_de;
            if (!s1_de) begin
                if (y_d == '0)        ref_d = x_d;
                else if (x_d != ref_q) err_d = 1'b1;
            end
        end
    end

    assign bus.pix_valid   = vld_q;
    assign bus.pix_data    = data_q;
    assign bus.pix_x       = x_q;
    assign bus.pix_y       = y_q;
    assign bus.pix_sof     = sof_q;
    assign bus.pix_eol     = eol_q;
    assign bus.frame_done  = fd_q;
    assign bus.meas_h_disp = mh_q;
    assign bus.meas_v_disp = mv_q;
    assign bus.err_size    = err_q;
    assign bus.locked      = lock_q;
endmodule

// File: tb/tb_lcd_rgb_capture.sv
module tb_lcd_rgb_capture;
    localparam int CNT_W = 11;
    localparam int VGAP  = 16;
    localparam int LOCKF = 2;
    localparam int MAXI  = (1 << CNT_W) - 1;

    logic lcd_pclk = 1'b0;
    logic rst;
    int   cyc = 0;
    bit   end_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lcd_rgb_capture_if #(.CNT_W(CNT_W)) bus();

    lcd_rgb_capture #(.CNT_W(CNT_W), .VGAP_MIN(VGAP), .LOCK_FRAMES(LOCKF)) dut (
        .lcd_pclk (lcd_pclk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    always #5 lcd_pclk = ~lcd_pclk;
    always @(posedge lcd_pclk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        int          x, y;
        bit          sof, eol, err, lock;
    } pexp_t;

    typedef struct {
        int h, v;
        bit err, lock;
    } fexp_t;

    pexp_t pq[$];
    fexp_t fq[$];

    // reference model state: frames are lists of lines split by long gaps
    int gap, nlines, ref_w, prev_h, prev_v, mc;
    bit in_frame, armed, ferr, lock_m;

    function automatic int clampi(input int v);
        return (v > MAXI) ? MAXI : v;
    endfunction

    task automatic model_reset();
        pq.delete();
        fq.delete();
        gap = 0; nlines = 0; ref_w = 0; prev_h = 0; prev_v = 0; mc = 0;
        in_frame = 0; armed = 0; ferr = 0; lock_m = 0;
    endtask

    task automatic close_frame();
        fexp_t f;
        bit same;
        f.h   = clampi(ref_w);
        f.v   = clampi(nlines);
        f.err = ferr;
        same  = (f.h == prev_h) && (f.v == prev_v);
        if (!ferr && same) mc = (mc < LOCKF) ? mc + 1 : mc;
        else               mc = ferr ? 0 : 1;
        lock_m   = (mc >= LOCKF);
        f.lock   = lock_m;
        prev_h   = f.h;
        prev_v   = f.v;
        in_frame = 0;
        fq.push_back(f);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge lcd_pclk);
            rst         = 1'b0;
            bus.lcd_de  = 1'b0;
            bus.lcd_rgb = 24'($urandom);
            gap++;
            if (gap == VGAP) begin
                if (in_frame) close_frame();
                armed = 1;
            end
        end
    endtask

    task automatic send_line(input int len, input int gap_after, input int rst_at = -1);
        pexp_t p;
        int j;
        if (armed && !in_frame) begin
            in_frame = 1; nlines = 0; ferr = 0; ref_w = len;
        end
        j = nlines;
        for (int i = 0; i < len; i++) begin
            @(negedge lcd_pclk);
            rst         = 1'b0;
            bus.lcd_de  = 1'b1;
            bus.lcd_rgb = 24'($urandom);
            if (in_frame) begin
                p.cyc  = cyc + 3;
                p.rgb  = bus.lcd_rgb;
                p.x    = clampi(i);
                p.y    = clampi(j);
                p.sof  = (i == 0) && (j == 0);
                p.eol  = (i == len - 1);
                ferr   = ferr || (i > MAXI) || (j > MAXI) ||
                         (p.eol && j > 0 && len != ref_w);
                p.err  = ferr;
                p.lock = lock_m;
                pq.push_back(p);
            end
            if (i == rst_at) begin
                #2 rst = 1'b1;
                model_reset();
            end
        end
        if (in_frame) nlines++;
        gap = 0;
        idle(gap_after);
    endtask

    task automatic send_frame(input int w, input int h, input int hb, input int vb,
                              input int bad_line = -1, input int bad_len = 0,
                              input int rst_line = -1, input int rst_px = -1);
        for (int j = 0; j < h; j++)
            send_line((j == bad_line) ? bad_len : w, (j == h - 1) ? vb : hb,
                      (j == rst_line) ? rst_px : -1);
    endtask

    // monitor / scoreboard: the only process touching checks/errors
    always begin : mon
        pexp_t pe;
        fexp_t fe;
        @(negedge lcd_pclk or posedge rst);
        if (end_req) begin
            checks++;
            if (pq.size() != 0 || fq.size() != 0) begin
                errors++;
                $display("FAIL leftover_expected pixels=%0d frames=%0d required 0/0", pq.size(), fq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (rst) begin
            #1;
            checks++;
            if (bus.pix_valid || bus.pix_sof || bus.pix_eol || bus.frame_done || bus.err_size ||
                bus.locked || bus.pix_data != 0 || bus.pix_x != 0 || bus.pix_y != 0 ||
                bus.meas_h_disp != 0 || bus.meas_v_disp != 0) begin
                errors++;
                $display("FAIL reset_outputs t=%0t valid=%0d x=%0d y=%0d fd=%0d mh=%0d mv=%0d err=%0d lock=%0d required all 0",
                         $time, bus.pix_valid, bus.pix_x, bus.pix_y, bus.frame_done,
                         bus.meas_h_disp, bus.meas_v_disp, bus.err_size, bus.locked);
            end
        end else begin
            if (bus.pix_valid) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pix_unexpected cyc=%0d x=%0d y=%0d", cyc, bus.pix_x, bus.pix_y);
                end else begin
                    pe = pq.pop_front();
                    if (cyc != pe.cyc || bus.pix_data != pe.rgb || int'(bus.pix_x) != pe.x ||
                        int'(bus.pix_y) != pe.y || bus.pix_sof != pe.sof || bus.pix_eol != pe.eol ||
                        bus.err_size != pe.err || bus.locked != pe.lock) begin
                        errors++;
                        $display("FAIL pix got cyc=%0d d=%06h x=%0d y=%0d sof=%0d eol=%0d err=%0d lock=%0d required cyc=%0d d=%06h x=%0d y=%0d sof=%0d eol=%0d err=%0d lock=%0d",
                                 cyc, bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol,
                                 bus.err_size, bus.locked, pe.cyc, pe.rgb, pe.x, pe.y, pe.sof,
                                 pe.eol, pe.err, pe.lock);
                    end
                end
            end
            if (bus.frame_done) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected cyc=%0d mh=%0d mv=%0d", cyc, bus.meas_h_disp, bus.meas_v_disp);
                end else begin
                    fe = fq.pop_front();
                    if (int'(bus.meas_h_disp) != fe.h || int'(bus.meas_v_disp) != fe.v ||
                        bus.err_size != fe.err || bus.locked != fe.lock) begin
                        errors++;
                        $display("FAIL frame got mh=%0d mv=%0d err=%0d lock=%0d required mh=%0d mv=%0d err=%0d lock=%0d",
                                 bus.meas_h_disp, bus.meas_v_disp, bus.err_size, bus.locked,
                                 fe.h, fe.v, fe.err, fe.lock);
                    end
                end
            end
        end
    end

    initial begin
        int w, h, bl, bln;
        rst         = 1'b1;
        bus.lcd_de  = 1'b0;
        bus.lcd_rgb = '0;
        model_reset();
        repeat (3) @(negedge lcd_pclk);
        idle(40);

        // nominal 8x4, lock on frame 2
        repeat (3) send_frame(8, 4, 4, 40);
        // short third line, then relock
        send_frame(8, 4, 4, 40, 2, 7);
        repeat (2) send_frame(8, 4, 4, 40);
        // size change while locked
        repeat (2) send_frame(6, 4, 4, 40);
        // h-blank just below / at the vertical threshold
        send_frame(8, 4, 15, 40);
        send_frame(8, 4, 16, 40);
        // 1-pixel lines
        repeat (2) send_frame(1, 3, 3, 20);
        // randomized geometry with occasional bad lines
        repeat (6) begin
            w   = $urandom_range(1, 10);
            h   = $urandom_range(1, 5);
            bl  = ($urandom_range(0, 3) == 0 && h > 1) ? $urandom_range(1, h - 1) : -1;
            bln = (w == 1) ? 2 : w - 1;
            send_frame(w, h, $urandom_range(1, 15), $urandom_range(16, 30), bl, bln);
        end
        // reset in the middle of line 2, then recovery
        send_frame(8, 4, 4, 40, -1, 0, 1, 3);
        repeat (2) send_frame(8, 4, 4, 40);
        // x saturation on an over-long line
        send_line(2100, 40);

        idle(10);
        @(negedge lcd_pclk);
        end_req = 1'b1;
        repeat (10) @(negedge lcd_pclk);
        $display("FAIL tb_watchdog summary not reached");
        $fatal(1);
    end
endmodule
